// File: rtl/pwm4_pkg.sv
// Shared types and constants for the pwm4 block.
// PWM4_PERIODS_EN (checked by pwm4) adds the saturating PERIODS counter.
package pwm4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int PERIODS_W = 8;

endpackage

// File: rtl/pwm4_duty_buf.sv
// Pending/active duty double buffer; the active value only changes on the wrap
// edge, so a new duty always starts at CNT=0.
module pwm4_duty_buf #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wrap,
    input  logic [WIDTH:0] duty,
    input  logic           duty_valid,
    output logic           duty_ready,
    output logic [WIDTH:0] active_duty
);

    logic           pending_full;
    logic [WIDTH:0] pending;
    logic           accept;

    assign duty_ready = !pending_full;
    assign accept     = duty_valid && duty_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_full <= 1'b0;
            pending      <= '0;
            active_duty  <= '0;
        end else if (wrap) begin
            // An offer landing on the wrap edge with an empty slot bypasses pending.
            pending_full <= 1'b0;
            if (pending_full)
                active_duty <= pending;
            else if (accept)
                active_duty <= duty;
        end else if (accept) begin
            pending      <= duty;
            pending_full <= 1'b1;
        end
    end

endmodule

// File: rtl/pwm4.sv
// PWM generator slaved to an upstream free-running counter: IDLE/ARM/RUN FSM,
// registered compare and period pulse. Define PWM4_PERIODS_EN for PERIODS.
module pwm4
    import pwm4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic [WIDTH-1:0]     CNT,
    input  logic                 WRAP,
    input  logic                 EN,
    input  logic [WIDTH:0]       DUTY,
    input  logic                 DUTY_VALID,
    output logic                 DUTY_READY,
    output logic                 PWM,
`ifdef PWM4_PERIODS_EN
    output logic [PERIODS_W-1:0] PERIODS,
`endif
    output logic                 PERIOD_DONE
);

    state_t         state;
    logic [WIDTH:0] active_duty;
    logic           running;

    pwm4_duty_buf #(.WIDTH(WIDTH)) u_duty_buf (
        .clk         (CLK),
        .rst_n       (RESETN),
        .wrap        (WRAP),
        .duty        (DUTY),
        .duty_valid  (DUTY_VALID),
        .duty_ready  (DUTY_READY),
        .active_duty (active_duty)
    );

    assign running = (state == RUN) && EN;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state       <= IDLE;
            PWM         <= 1'b0;
            PERIOD_DONE <= 1'b0;
        end else begin
            // Zero-extended compare: duty 0 never fires, duty 2^WIDTH always does.
            PWM         <= running && ({1'b0, CNT} < active_duty);
            PERIOD_DONE <= running && WRAP;
            case (state)
                IDLE: if (EN) state <= ARM;
                ARM: begin
                    if (!EN)
                        state <= IDLE;
                    else if (WRAP)
                        state <= RUN;
                end
                RUN: if (!EN) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PWM4_PERIODS_EN
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN)
            PERIODS <= '0;
        else if ((state == RUN) && !EN)
            PERIODS <= '0;
        else if (running && WRAP && (PERIODS != {PERIODS_W{1'b1}}))
            PERIODS <= PERIODS + 1'b1;
    end
`endif

endmodule
